// File: rtl/mdu_seq_pkg.sv
// ============================================================================
// mdu_seq_pkg : shared types and constants for the multiply/divide sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_enum;

  localparam int MDU_DIV_ITERS = 32;

endpackage

`default_nettype wire

// File: rtl/mdu_seq_if.sv
// ============================================================================
// mdu_seq_if : EXE-side request/result bundle for the multiply/divide sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface mdu_seq_if #(
  parameter int WIDTH = 32
);

  logic             mdu_start;
  logic             mdu_is_div;
  logic             mdu_sign;
  logic [WIDTH-1:0] mdu_src1;
  logic [WIDTH-1:0] mdu_src2;
  logic             mdu_flush;
  logic             mdu_stall_req;
  logic             mdu_hilowe;
  logic [WIDTH-1:0] mdu_hi;
  logic [WIDTH-1:0] mdu_lo;

  modport master (
    output mdu_start, mdu_is_div, mdu_sign, mdu_src1, mdu_src2, mdu_flush,
    input  mdu_stall_req, mdu_hilowe, mdu_hi, mdu_lo
  );

  modport slave (
    input  mdu_start, mdu_is_div, mdu_sign, mdu_src1, mdu_src2, mdu_flush,
    output mdu_stall_req, mdu_hilowe, mdu_hi, mdu_lo
  );

endinterface

`default_nettype wire

// File: rtl/mdu_seq_div_step.sv
// ============================================================================
// mdu_seq_div_step : one combinational restoring-divide iteration
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_seq_div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] rem_i,
  input  wire logic             dvd_bit_i,
  input  wire logic [WIDTH-1:0] divisor_i,
  output logic      [WIDTH-1:0] rem_o,
  output logic                  qbit_o
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // The shifted remainder is below 2*divisor, so the msb of the difference
  // is set exactly when the trial subtraction goes negative.
  assign w_shift = {rem_i, dvd_bit_i};
  assign w_diff  = w_shift - {1'b0, divisor_i};
  assign qbit_o  = ~w_diff[WIDTH];
  assign rem_o   = qbit_o ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
// mdu_seq : EXE-stage MULT/MULTU/DIV/DIVU sequencer producing HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = MDU_DIV_ITERS
) (
  input wire logic    cpu_clk,
  input wire logic    cpu_rst,
  mdu_seq_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_enum    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sign_q, sign_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_step_rem;
  logic               w_step_qbit;

  assign w_accept = (state_q == IDLE) & bus.mdu_start & ~bus.mdu_flush;
  assign w_a_neg  = bus.mdu_sign & bus.mdu_src1[WIDTH-1];
  assign w_b_neg  = bus.mdu_sign & bus.mdu_src2[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -bus.mdu_src1 : bus.mdu_src1;
  assign w_b_abs  = w_b_neg ? -bus.mdu_src2 : bus.mdu_src2;

  // Extending to 2*WIDTH makes one unsigned multiply serve both modes.
  assign w_ext_a = {{WIDTH{sign_q & opa_q[WIDTH-1]}}, opa_q};
  assign w_ext_b = {{WIDTH{sign_q & opb_q[WIDTH-1]}}, opb_q};
  assign w_prod  = w_ext_a * w_ext_b;

  mdu_seq_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .dvd_bit_i (opa_q[WIDTH-1]),
    .divisor_i (opb_q),
    .rem_o     (w_step_rem),
    .qbit_o    (w_step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sign_d  = sign_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          sign_d = bus.mdu_sign;
          if (!bus.mdu_is_div) begin
            opa_d   = bus.mdu_src1;
            opb_d   = bus.mdu_src2;
            state_d = MUL;
          end else if (bus.mdu_src2 != '0) begin
            opa_d   = w_a_abs;
            opb_d   = w_b_abs;
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = w_a_neg ^ w_b_neg;
            negr_d  = w_a_neg;
            state_d = DIV;
          end else begin
            hi_d    = bus.mdu_src1;
            lo_d    = '1;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        if (bus.mdu_flush) begin
          state_d = IDLE;
        end else begin
          hi_d    = w_prod[2*WIDTH-1:WIDTH];
          lo_d    = w_prod[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        // opa_q shifts the dividend out of its top while quotient bits enter below.
        if (bus.mdu_flush) begin
          state_d = IDLE;
        end else begin
          rem_d = w_step_rem;
          opa_d = {opa_q[WIDTH-2:0], w_step_qbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (bus.mdu_flush) begin
          state_d = IDLE;
        end else begin
          hi_d    = negr_q ? -rem_q : rem_q;
          lo_d    = negq_q ? -opa_q : opa_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sign_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sign_q  <= sign_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign bus.mdu_stall_req = w_accept | (state_q == MUL) | (state_q == DIV) | (state_q == FIX);
  assign bus.mdu_hilowe    = (state_q == DONE) & ~bus.mdu_flush;
  assign bus.mdu_hi        = hi_q;
  assign bus.mdu_lo        = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// ============================================================================
// tb_mdu_seq : directed bench for mdu_seq with an arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mdu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   hilowe_cnt = 0;
  bit   chk_en = 1'b0;

  // Reference state: cycles left until the DONE cycle, pending result, visible HI/LO.
  int          m_left = 0;
  logic [63:0] m_res  = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32)) dut (
    .cpu_clk (clk),
    .cpu_rst (rst),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input bit is_div, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    longint q;
    longint r;
    if (!is_div) begin
      if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
      return 64'(a) * 64'(b);
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int ref_latency(input bit is_div, input logic [31:0] b);
    if (!is_div) return 2;
    if (b == 32'd0) return 1;
    return 34;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 1) begin
      if (bus.mdu_flush) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 1) {m_hi, m_lo} = m_res;
      end
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (bus.mdu_start && !bus.mdu_flush) begin
      m_res  = ref_result(bus.mdu_is_div, bus.mdu_sign, bus.mdu_src1, bus.mdu_src2);
      m_left = ref_latency(bus.mdu_is_div, bus.mdu_src2);
      if (m_left == 1) {m_hi, m_lo} = m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_stall", 64'(bus.mdu_stall_req),
          64'((m_left == 0 && bus.mdu_start && !bus.mdu_flush) || m_left > 1));
      chk("model_hilowe", 64'(bus.mdu_hilowe), 64'(m_left == 1 && !bus.mdu_flush));
      chk("model_hi", 64'(bus.mdu_hi), 64'(m_hi));
      chk("model_lo", 64'(bus.mdu_lo), 64'(m_lo));
      if (bus.mdu_hilowe) hilowe_cnt++;
    end
  end

  // Issues one op in the current cycle (cycle 0) and checks latency and HI/LO
  // against hand-computed literals; noise pulses start in cycles 5 and 20.
  task automatic run_op(input string name, input bit is_div, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input bit noise);
    int cyc;
    bit seen;
    bus.mdu_start  = 1'b1;
    bus.mdu_is_div = is_div;
    bus.mdu_sign   = sgn;
    bus.mdu_src1   = a;
    bus.mdu_src2   = b;
    @(negedge clk);
    chk({name, "_stall_c0"}, 64'(bus.mdu_stall_req), 64'd1);
    @(posedge clk);
    #1 bus.mdu_start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      if (bus.mdu_hilowe) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1 cyc++;
        if (noise) begin
          bus.mdu_start  = (cyc == 5 || cyc == 20);
          bus.mdu_is_div = 1'b0;
          bus.mdu_src1   = 32'h0000_0003;
          bus.mdu_src2   = 32'h0000_0009;
        end
      end
    end
    chk({name, "_latency"}, 64'(seen ? cyc : -1), 64'(exp_lat));
    chk({name, "_hi"}, 64'(bus.mdu_hi), 64'(exp_hi));
    chk({name, "_lo"}, 64'(bus.mdu_lo), 64'(exp_lo));
    chk({name, "_stall_done"}, 64'(bus.mdu_stall_req), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Starts DIVU 100/7, aborts it in cycle 10 by flush or reset, checks cycle 11.
  task automatic abort_op(input string name, input bit use_rst,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n0;
    bus.mdu_start  = 1'b1;
    bus.mdu_is_div = 1'b1;
    bus.mdu_sign   = 1'b0;
    bus.mdu_src1   = 32'd100;
    bus.mdu_src2   = 32'd7;
    @(posedge clk);
    #1 bus.mdu_start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) rst = 1'b1;
    else bus.mdu_flush = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.mdu_flush = 1'b0;
    n0            = hilowe_cnt;
    @(negedge clk);
    chk({name, "_stall"}, 64'(bus.mdu_stall_req), 64'd0);
    chk({name, "_hilowe"}, 64'(bus.mdu_hilowe), 64'd0);
    chk({name, "_hi"}, 64'(bus.mdu_hi), 64'(exp_hi));
    chk({name, "_lo"}, 64'(bus.mdu_lo), 64'(exp_lo));
    repeat (40) @(posedge clk);
    #1;
    chk({name, "_no_write"}, 64'(hilowe_cnt), 64'(n0));
  endtask

  initial begin
    bus.mdu_start  = 1'b0;
    bus.mdu_is_div = 1'b0;
    bus.mdu_sign   = 1'b0;
    bus.mdu_src1   = '0;
    bus.mdu_src2   = '0;
    bus.mdu_flush  = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", 64'(bus.mdu_hi), 64'd0);
    chk("reset_lo", 64'(bus.mdu_lo), 64'd0);
    chk("reset_hilowe", 64'(bus.mdu_hilowe), 64'd0);
    chk("reset_stall", 64'(bus.mdu_stall_req), 64'd0);
    @(posedge clk);
    #1;

    run_op("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 2, 1'b0);
    run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 2, 1'b0);
    run_op("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b1);
    run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 34, 1'b0);
    run_op("divu", 1'b1, 1'b0, 32'd100, 32'd7,
           32'h0000_0002, 32'h0000_000E, 34, 1'b0);
    run_op("divu_zero", 1'b1, 1'b0, 32'd5, 32'd0,
           32'h0000_0005, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("mult_b2b", 1'b0, 1'b1, 32'h0000_3039, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_9F8E, 2, 1'b0);

    abort_op("flush_abort", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_9F8E);
    abort_op("rst_abort", 1'b1, 32'h0000_0000, 32'h0000_0000);

    run_op("multu_after", 1'b0, 1'b0, 32'd6, 32'd7,
           32'h0000_0000, 32'h0000_002A, 2, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
